// File: rtl/srambank_arb_2p.sv
// Two-client arbiter and sequencer for one synchronous SRAM bank; all bank pins are registered.
// Optional build macro SRAMBANK_ARB_FIXED_PRIO_EN makes port 0 always win ties instead of round-robin.
module srambank_arb_2p #(
    parameter int AW = 9,
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic [AW-1:0] bank_address,
    output logic [DW-1:0] bank_wd,
    output logic          bank_banksel,
    output logic          bank_read,
    output logic          bank_write,
    input  logic [DW-1:0] bank_dataout
);

    typedef struct packed {
        logic is_read;
        logic port;
    } tag_t;

    logic          w_ready0, w_ready1;
    logic          w_acc0, w_acc1, w_acc;
    logic          w_port, w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    logic [AW-1:0] r_bank_address;
    logic [DW-1:0] r_bank_wd;
    logic          r_bank_banksel, r_bank_read, r_bank_write;
    tag_t          r_tag_iss, r_tag_bnk;
    logic          r_rsp0_valid, r_rsp1_valid;
    logic [DW-1:0] r_rsp0_rdata, r_rsp1_rdata;

`ifdef SRAMBANK_ARB_FIXED_PRIO_EN
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_ready0 = req0_valid;
        w_ready1 = req1_valid & ~req0_valid;
    end
`else
    logic r_last;

    always_comb begin
        w_ready0 = req0_valid & (~req1_valid | r_last);
        w_ready1 = req1_valid & (~req0_valid | ~r_last);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_last <= 1'b1;
        else if (w_acc)
            r_last <= w_acc1;
    end
`endif

    assign w_acc0  = req0_valid & w_ready0;
    assign w_acc1  = req1_valid & w_ready1;
    assign w_acc   = w_acc0 | w_acc1;
    assign w_port  = w_acc1;
    assign w_we    = w_acc1 ? req1_we    : req0_we;
    assign w_addr  = w_acc1 ? req1_addr  : req0_addr;
    assign w_wdata = w_acc1 ? req1_wdata : req0_wdata;

    // Issue stage drives the bank; the tag then follows the read through the bank's sample edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bank_address <= '0;
            r_bank_wd      <= '0;
            r_bank_banksel <= 1'b0;
            r_bank_read    <= 1'b0;
            r_bank_write   <= 1'b0;
            r_tag_iss      <= '0;
            r_tag_bnk      <= '0;
        end else begin
            r_bank_banksel <= w_acc;
            r_bank_read    <= w_acc & ~w_we;
            r_bank_write   <= w_acc & w_we;
            r_tag_iss      <= '{is_read: w_acc & ~w_we, port: w_port};
            r_tag_bnk      <= r_tag_iss;
            if (w_acc) begin
                r_bank_address <= w_addr;
                if (w_we)
                    r_bank_wd <= w_wdata;
            end
        end
    end

    // bank_dataout is valid the cycle after the bank samples the read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            r_rsp0_valid <= r_tag_bnk.is_read & ~r_tag_bnk.port;
            r_rsp1_valid <= r_tag_bnk.is_read & r_tag_bnk.port;
            if (r_tag_bnk.is_read & ~r_tag_bnk.port)
                r_rsp0_rdata <= bank_dataout;
            if (r_tag_bnk.is_read & r_tag_bnk.port)
                r_rsp1_rdata <= bank_dataout;
        end
    end

    assign req0_ready   = w_ready0;
    assign req1_ready   = w_ready1;
    assign rsp0_valid   = r_rsp0_valid;
    assign rsp1_valid   = r_rsp1_valid;
    assign rsp0_rdata   = r_rsp0_rdata;
    assign rsp1_rdata   = r_rsp1_rdata;
    assign bank_address = r_bank_address;
    assign bank_wd      = r_bank_wd;
    assign bank_banksel = r_bank_banksel;
    assign bank_read    = r_bank_read;
    assign bank_write   = r_bank_write;

endmodule

// File: tb/tb_srambank_arb_2p.sv
// Randomized self-checking bench for srambank_arb_2p: behavioural SRAM bank plus a scoreboard model.
// Honours SRAMBANK_ARB_FIXED_PRIO_EN for the expected arbitration rule.
module tb_srambank_arb_2p;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req0_we = 1'b0;
    logic [8:0]  req0_addr = '0;
    logic [17:0] req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_we = 1'b0;
    logic [8:0]  req1_addr = '0;
    logic [17:0] req1_wdata = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [17:0] rsp0_rdata, rsp1_rdata;
    logic [8:0]  bank_address;
    logic [17:0] bank_wd;
    logic        bank_banksel, bank_read, bank_write;
    logic [17:0] bank_dout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    logic [17:0] ref_mem [512];
    logic        ref_last;
    logic        exp_v0 [4];
    logic        exp_v1 [4];
    logic [17:0] exp_d0 [4];
    logic [17:0] exp_d1 [4];
    logic [17:0] held0, held1;

    // values observed in the most recent cycle
    logic        g_rdy0, g_rdy1, g_rsp0_v, g_rsp1_v;
    logic [17:0] g_rsp0_d, g_rsp1_d;

    // behavioural bank: memory and latched output are only touched on banksel
    logic [17:0] bank_mem [512];
    logic        mem_init = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++)
                bank_mem[i] <= 18'((i * 2731 + 5) & 18'h3FFFF);
        end else if (bank_banksel) begin
            if (bank_write) bank_mem[bank_address] <= bank_wd;
            if (bank_read)  bank_dout <= bank_mem[bank_address];
        end
    end

    srambank_arb_2p #(.AW(9), .DW(18)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .bank_address(bank_address), .bank_wd(bank_wd),
        .bank_banksel(bank_banksel), .bank_read(bank_read), .bank_write(bank_write),
        .bank_dataout(bank_dout)
    );

    function automatic void clear_model();
        ref_last = 1'b1;
        held0 = '0;
        held1 = '0;
        for (int i = 0; i < 4; i++) begin
            exp_v0[i] = 1'b0;
            exp_v1[i] = 1'b0;
            exp_d0[i] = '0;
            exp_d1[i] = '0;
        end
    endfunction

    // Drives one cycle of requests, checks everything visible in it, and advances the model.
    task automatic run_cycle(input logic v0, input logic we0, input logic [8:0] a0, input logic [17:0] d0,
                             input logic v1, input logic we1, input logic [8:0] a1, input logic [17:0] d1);
        logic e0, e1;
        int   slot, due;
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        @(negedge clk);
`ifdef SRAMBANK_ARB_FIXED_PRIO_EN
        e0 = v0;
        e1 = v1 && !v0;
`else
        e0 = v0 && (!v1 || ref_last == 1'b1);
        e1 = v1 && (!v0 || ref_last == 1'b0);
`endif
        total++;
        if (req0_ready !== e0 || req1_ready !== e1) begin
            bad++;
            $display("FAIL ready cyc=%0d got=%b%b exp=%b%b", cyc, req0_ready, req1_ready, e0, e1);
        end
        total++;
        if ((bank_read & bank_write) !== 1'b0) begin
            bad++;
            $display("FAIL rd_wr_excl cyc=%0d got rd=%b wr=%b exp not both", cyc, bank_read, bank_write);
        end
        slot = cyc % 4;
        if (exp_v0[slot]) held0 = exp_d0[slot];
        if (exp_v1[slot]) held1 = exp_d1[slot];
        total++;
        if (rsp0_valid !== exp_v0[slot] || rsp0_rdata !== held0) begin
            bad++;
            $display("FAIL rsp0 cyc=%0d got v=%b d=%h exp v=%b d=%h", cyc, rsp0_valid, rsp0_rdata, exp_v0[slot], held0);
        end
        total++;
        if (rsp1_valid !== exp_v1[slot] || rsp1_rdata !== held1) begin
            bad++;
            $display("FAIL rsp1 cyc=%0d got v=%b d=%h exp v=%b d=%h", cyc, rsp1_valid, rsp1_rdata, exp_v1[slot], held1);
        end
        g_rdy0 = req0_ready; g_rdy1 = req1_ready;
        g_rsp0_v = rsp0_valid; g_rsp0_d = rsp0_rdata;
        g_rsp1_v = rsp1_valid; g_rsp1_d = rsp1_rdata;
        exp_v0[slot] = 1'b0;
        exp_v1[slot] = 1'b0;
        due = (cyc + 3) % 4;
        if (e0) begin
            if (we0) ref_mem[a0] = d0;
            else begin exp_v0[due] = 1'b1; exp_d0[due] = ref_mem[a0]; end
            ref_last = 1'b0;
        end
        if (e1) begin
            if (we1) ref_mem[a1] = d1;
            else begin exp_v1[due] = 1'b1; exp_d1[due] = ref_mem[a1]; end
            ref_last = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            run_cycle(1'b0, 1'b0, 9'h0, 18'h0, 1'b0, 1'b0, 9'h0, 18'h0);
    endtask

    // Asserts reset between edges and checks that outputs clear asynchronously.
    task automatic apply_reset();
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if ({bank_banksel, bank_read, bank_write, rsp0_valid, rsp1_valid} !== 5'b0 ||
            bank_address !== 9'h0 || bank_wd !== 18'h0 || rsp0_rdata !== 18'h0 || rsp1_rdata !== 18'h0) begin
            bad++;
            $display("FAIL reset_clear got sel/rd/wr/v0/v1=%b%b%b%b%b addr=%h wd=%h d0=%h d1=%h exp all zero",
                     bank_banksel, bank_read, bank_write, rsp0_valid, rsp1_valid,
                     bank_address, bank_wd, rsp0_rdata, rsp1_rdata);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        mem_init = 1'b0;
        apply_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_tie got=%b%b exp=10", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        total++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_ready got=%b%b exp=00", req0_ready, req1_ready);
        end
    endtask

    task automatic test_write_read();
        int k;
        apply_reset();
        run_cycle(1'b1, 1'b1, 9'h005, 18'h2A5A5, 1'b0, 1'b0, 9'h0, 18'h0);
        k = cyc;
        run_cycle(1'b1, 1'b0, 9'h005, 18'h0, 1'b0, 1'b0, 9'h0, 18'h0);
        total++;
        if (g_rdy0 !== 1'b1) begin
            bad++;
            $display("FAIL wr_rd_accept got=%b exp=1", g_rdy0);
        end
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            total++;
            if (g_rsp0_v !== (i == 3) || g_rsp1_v !== 1'b0 || (i == 3 && g_rsp0_d !== 18'h2A5A5)) begin
                bad++;
                $display("FAIL wr_rd_lat off=%0d got v0=%b v1=%b d=%h exp v0=%b v1=0 d=2a5a5",
                         i, g_rsp0_v, g_rsp1_v, g_rsp0_d, (i == 3));
            end
        end
        if (k < 0) bad++;
    endtask

    task automatic test_round_robin();
        logic exp_port [4];
        logic got_v0 [8];
        logic got_v1 [8];
`ifdef SRAMBANK_ARB_FIXED_PRIO_EN
        exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 4) run_cycle(1'b1, 1'b0, 9'h010, 18'h0, 1'b1, 1'b0, 9'h011, 18'h0);
            else       idle(1);
            got_v0[i] = g_rsp0_v;
            got_v1[i] = g_rsp1_v;
            if (i < 4) begin
                total++;
                if (g_rdy0 !== ~exp_port[i] || g_rdy1 !== exp_port[i]) begin
                    bad++;
                    $display("FAIL rr_grant n=%0d got=%b%b exp port %0d", i, g_rdy0, g_rdy1, exp_port[i]);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_v0[i + 3] !== ~exp_port[i] || got_v1[i + 3] !== exp_port[i]) begin
                bad++;
                $display("FAIL rr_rsp n=%0d got v0=%b v1=%b exp port %0d", i, got_v0[i + 3], got_v1[i + 3], exp_port[i]);
            end
        end
    endtask

    task automatic test_cross_raw();
        run_cycle(1'b0, 1'b0, 9'h0, 18'h0, 1'b1, 1'b1, 9'h1FF, 18'h3FFFF);
        run_cycle(1'b1, 1'b0, 9'h1FF, 18'h0, 1'b0, 1'b0, 9'h0, 18'h0);
        idle(3);
        total++;
        if (g_rsp0_v !== 1'b1 || g_rsp0_d !== 18'h3FFFF) begin
            bad++;
            $display("FAIL cross_raw got v=%b d=%h exp v=1 d=3ffff", g_rsp0_v, g_rsp0_d);
        end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        run_cycle(1'b1, 1'b0, 9'h020, 18'h0, 1'b0, 1'b0, 9'h0, 18'h0);
        total++;
        if (bank_read !== 1'b1 || bank_banksel !== 1'b1 || bank_address !== 9'h020) begin
            bad++;
            $display("FAIL mid_issue got sel=%b rd=%b addr=%h exp 1 1 020", bank_banksel, bank_read, bank_address);
        end
        apply_reset();
        idle(4);
        run_cycle(1'b1, 1'b0, 9'h020, 18'h0, 1'b0, 1'b0, 9'h0, 18'h0);
        idle(3);
        total++;
        if (g_rsp0_v !== 1'b1 || g_rsp0_d !== ref_mem[9'h020]) begin
            bad++;
            $display("FAIL mid_recover got v=%b d=%h exp v=1 d=%h", g_rsp0_v, g_rsp0_d, ref_mem[9'h020]);
        end
    endtask

    task automatic test_random();
        logic        v0, v1, w0, w1;
        logic [8:0]  a0, a1;
        logic [17:0] d0, d1;
        for (int i = 0; i < 10000; i++) begin
            v0 = ($urandom_range(0, 9) < 7);
            v1 = ($urandom_range(0, 9) < 7);
            w0 = $urandom_range(0, 2) == 0;
            w1 = $urandom_range(0, 2) == 0;
            a0 = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
            d0 = 18'($urandom);
            d1 = 18'($urandom);
            run_cycle(v0, w0, a0, d0, v1, w1, a1, d1);
        end
        idle(4);
    endtask

    initial begin
        for (int i = 0; i < 512; i++)
            ref_mem[i] = 18'((i * 2731 + 5) & 18'h3FFFF);
        clear_model();
        test_reset();
        test_write_read();
        test_round_robin();
        test_cross_raw();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
